lift_call_dispatcher: RTL and testbench

//  Request side of the lift floor interface: latches hall/car call buttons, compares

---
 rtl/lift_call_dispatcher.sv | 163 ++++++++++++++++
 tb/tb_lift_call_dispatcher.sv | 106 ++++++++++
 2 files changed

// File: rtl/lift_call_dispatcher.sv
// lift_call_dispatcher: latches call buttons, runs a SCAN sweep against the floor code and drives move/door commands
module lift_call_dispatcher #(
    parameter int NUM_FLOORS   = 3,
    parameter int FLOOR_W      = 2,
    parameter int DOOR_CYCLES  = 8,
    parameter int MOVE_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic [NUM_FLOORS-1:0] call,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  fault
);
    localparam int DTW = $clog2(DOOR_CYCLES + 1);
    localparam int MTW = $clog2(MOVE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR, FAULT} state_t;

    state_t                state, state_n;
    logic [NUM_FLOORS-1:0] call_q, pend_n, here_mask, edges, set, clr;
    logic [FLOOR_W-1:0]    floor_q;
    logic [DTW-1:0]        door_timer, dt_n;
    logic [MTW-1:0]        move_timer, mt_n;
    logic                  mu_n, md_n, do_n, dir_n, fault_n;
    logic                  here, up_ahead, down_ahead, at_top, at_bot, illegal, floor_chg, door_hit, end_dir;

    // floor decode and pending look-ahead relative to the current floor
    always_comb begin
        here_mask  = '0;
        up_ahead   = 1'b0;
        down_ahead = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            here_mask[i] = int'(floor) == i;
            if (i > int'(floor)) up_ahead = up_ahead | pending[i];
            if (i < int'(floor)) down_ahead = down_ahead | pending[i];
        end
        here      = |(pending & here_mask);
        illegal   = int'(floor) >= NUM_FLOORS;
        at_top    = int'(floor) == NUM_FLOORS - 1;
        at_bot    = floor == '0;
        end_dir   = at_top ? 1'b0 : (at_bot ? 1'b1 : dir_up);
        floor_chg = floor != floor_q;
        edges     = call & ~call_q;
        door_hit  = (state == DOOR) && |(edges & here_mask);
        set       = edges & ~((state == DOOR) ? here_mask : '0);
    end

    // next-state and registered-output decisions
    always_comb begin
        state_n = state;
        mu_n    = 1'b0;
        md_n    = 1'b0;
        do_n    = 1'b0;
        dir_n   = dir_up;
        fault_n = fault;
        dt_n    = door_timer;
        mt_n    = move_timer;
        clr     = '0;
        case (state)
            IDLE: begin
                if (here) begin
                    state_n = DOOR;
                    clr     = here_mask;
                    do_n    = 1'b1;
                    dt_n    = DTW'(DOOR_CYCLES);
                    dir_n   = end_dir;
                end else if (dir_up ? up_ahead : down_ahead) begin
                    state_n = MOVING;
                    mu_n    = dir_up;
                    md_n    = ~dir_up;
                    mt_n    = '0;
                end else if (dir_up ? down_ahead : up_ahead) begin
                    state_n = MOVING;
                    dir_n   = ~dir_up;
                    mu_n    = ~dir_up;
                    md_n    = dir_up;
                    mt_n    = '0;
                end
            end
            MOVING: begin
                if (floor_chg) begin
                    mt_n = '0;
                    if (here) begin
                        state_n = DOOR;
                        clr     = here_mask;
                        do_n    = 1'b1;
                        dt_n    = DTW'(DOOR_CYCLES);
                        dir_n   = end_dir;
                    end else if (dir_up ? at_top : at_bot) begin
                        // reached an end floor with nothing to serve there: stop and turn
                        state_n = IDLE;
                        dir_n   = end_dir;
                    end else begin
                        mu_n = dir_up;
                        md_n = ~dir_up;
                    end
                end else if (move_timer == MTW'(MOVE_TIMEOUT - 1)) begin
                    state_n = FAULT;
                    fault_n = 1'b1;
                end else begin
                    mt_n = move_timer + MTW'(1);
                    mu_n = dir_up;
                    md_n = ~dir_up;
                end
            end
            DOOR: begin
                if (door_hit) begin
                    dt_n = DTW'(DOOR_CYCLES);
                    do_n = 1'b1;
                end else if (door_timer <= DTW'(1)) begin
                    state_n = IDLE;
                    dt_n    = '0;
                end else begin
                    dt_n = door_timer - DTW'(1);
                    do_n = 1'b1;
                end
            end
            default: fault_n = 1'b1;
        endcase
        if (illegal) begin
            state_n = FAULT;
            fault_n = 1'b1;
            mu_n    = 1'b0;
            md_n    = 1'b0;
            do_n    = 1'b0;
        end
        pend_n = (state_n == FAULT) ? pending : ((pending | set) & ~clr);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= IDLE;
            pending    <= '0;
            move_up    <= 1'b0;
            move_down  <= 1'b0;
            door_open  <= 1'b0;
            dir_up     <= 1'b1;
            fault      <= 1'b0;
            door_timer <= '0;
            move_timer <= '0;
            call_q     <= '0;
            floor_q    <= '0;
        end else begin
            state      <= state_n;
            pending    <= pend_n;
            move_up    <= mu_n;
            move_down  <= md_n;
            door_open  <= do_n;
            dir_up     <= dir_n;
            fault      <= fault_n;
            door_timer <= dt_n;
            move_timer <= mt_n;
            call_q     <= call;
            floor_q    <= floor;
        end
    end
endmodule

// File: tb/tb_lift_call_dispatcher.sv
// tb_lift_call_dispatcher: directed sweep, door, reload, fault and reset scenarios against expected output vectors
module tb_lift_call_dispatcher;
    logic       CLK = 1'b0;
    logic       RES;
    logic [2:0] call;
    logic [1:0] floor;
    logic       move_up, move_down, door_open, dir_up, fault;
    logic [2:0] pending;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         ncmp = 0;
    int         nfail = 0;

    lift_call_dispatcher dut (
        .CLK(CLK), .RES(RES), .call(call), .floor(floor),
        .move_up(move_up), .move_down(move_down), .door_open(door_open),
        .pending(pending), .dir_up(dir_up), .fault(fault)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] ev(input logic mu, md, dr, input logic [2:0] p, input logic d, f);
        return {mu, md, dr, p, d, f};
    endfunction

    task automatic nxt(input int k);
        repeat (k) @(negedge CLK);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [7:0] obs, e;
        string      tag;
        obs = {move_up, move_down, door_open, pending, dir_up, fault};
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        ncmp++;
        assert (obs === e) else begin
            nfail++;
            $error("FAIL %s: observed mu,md,door,pend,dir,fault=%b expected %b", tag, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] e);
        expect_out(tag, e);
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RES = 1'b1; call = 3'b000; floor = 2'b00;
        nxt(1);
        chk("reset", ev(0,0,0,3'b000,1,0));
        RES = 1'b0; call = 3'b100;
        nxt(1); chk("t1_latch", ev(0,0,0,3'b100,1,0)); call = 3'b000;
        nxt(1); chk("t1_move", ev(1,0,0,3'b100,1,0)); floor = 2'd1;
        nxt(1); chk("t1_pass", ev(1,0,0,3'b100,1,0)); floor = 2'd2;
        nxt(1); chk("t1_door", ev(0,0,1,3'b000,0,0));
        nxt(7); chk("t1_door_last", ev(0,0,1,3'b000,0,0));
        nxt(1); chk("t1_idle", ev(0,0,0,3'b000,0,0)); call = 3'b001;
        nxt(1); chk("t2_latch", ev(0,0,0,3'b001,0,0)); call = 3'b000;
        nxt(1); chk("t2_move", ev(0,1,0,3'b001,0,0)); floor = 2'd1;
        nxt(1); chk("t2_pass", ev(0,1,0,3'b001,0,0)); floor = 2'd0;
        nxt(1); chk("t2_door", ev(0,0,1,3'b000,1,0));
        nxt(8); chk("t2_idle", ev(0,0,0,3'b000,1,0)); call = 3'b100;
        nxt(1); call = 3'b000;
        nxt(1); chk("t3_move", ev(1,0,0,3'b100,1,0)); call = 3'b011;
        nxt(1); chk("t3_merge", ev(1,0,0,3'b111,1,0)); call = 3'b000; floor = 2'd1;
        nxt(1); chk("t3_stop1", ev(0,0,1,3'b101,1,0));
        nxt(4); call = 3'b010;
        nxt(1); chk("t4_reload", ev(0,0,1,3'b101,1,0)); call = 3'b000;
        nxt(7); chk("t4_door_held", ev(0,0,1,3'b101,1,0));
        nxt(1); chk("t4_door_end", ev(0,0,0,3'b101,1,0));
        nxt(1); chk("t3_up_again", ev(1,0,0,3'b101,1,0)); floor = 2'd2;
        nxt(1); chk("t3_stop2", ev(0,0,1,3'b001,0,0));
        nxt(8); chk("t3_idle2", ev(0,0,0,3'b001,0,0));
        nxt(1); chk("t3_reverse", ev(0,1,0,3'b001,0,0)); floor = 2'd1;
        nxt(1); chk("t3_pass1", ev(0,1,0,3'b001,0,0)); floor = 2'd0;
        nxt(1); chk("t3_stop0", ev(0,0,1,3'b000,1,0));
        nxt(8); chk("t3_idle0", ev(0,0,0,3'b000,1,0)); call = 3'b100;
        nxt(1); call = 3'b000;
        nxt(1); call = 3'b001;
        nxt(1); chk("t6_moving", ev(1,0,0,3'b101,1,0)); call = 3'b000; RES = 1'b1;
        nxt(1); chk("t6_reset", ev(0,0,0,3'b000,1,0)); RES = 1'b0; floor = 2'd3;
        nxt(1); chk("t5_illegal", ev(0,0,0,3'b000,1,1)); floor = 2'd0;
        nxt(1); chk("t5_sticky", ev(0,0,0,3'b000,1,1)); RES = 1'b1;
        nxt(1); chk("t5_clear", ev(0,0,0,3'b000,1,0)); RES = 1'b0; call = 3'b010;
        nxt(1); call = 3'b000;
        nxt(1); chk("t5_move", ev(1,0,0,3'b010,1,0));
        nxt(63); chk("t5_before_to", ev(1,0,0,3'b010,1,0));
        nxt(1); chk("t5_timeout", ev(0,0,0,3'b010,1,1)); RES = 1'b1;
        nxt(1); chk("t5_to_clear", ev(0,0,0,3'b000,1,0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
